logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined multi-bit logic unit. Successor to the single-bit gate set.

---
 rtl/logic_unit_pipe.sv | 167 ++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit: eight ops on WIDTH-bit operands plus zero/ones/parity flags.
// Latency: 2 cycles from input accept to out_valid; one beat per cycle sustained.
// Backpressure: in_ready = !s1_valid || s1 advances (combinational from out_ready); S2 holds until taken.
// Optional: define LOGIC_UNIT_POPCOUNT_EN to add out_popcnt (count of ones in out_y, registered in S2).
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int PCW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
`ifdef LOGIC_UNIT_POPCOUNT_EN
    output logic [PCW-1:0]   out_popcnt,
`endif
    output logic [CNT_W-1:0] op_count
);

    // Opcode encoding
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NOTA  = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    // Stage 1: captured operands
    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    // Stage 2: result and flags
    logic             s2_valid_q;
    logic [2:0]       s2_op_q;
    logic [WIDTH-1:0] s2_y_q;
    logic             s2_zero_q;
    logic             s2_ones_q;
    logic             s2_par_q;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] y_d;
    logic             s2_load;
    logic             in_fire;

    // S2 takes the S1 beat when it is empty or its own beat leaves this cycle.
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Bitwise operation on the S1 operands
    always_comb begin
        y_d = '0;
        case (s1_op_q)
            OP_AND:   y_d = s1_a_q & s1_b_q;
            OP_OR:    y_d = s1_a_q | s1_b_q;
            OP_NOTA:  y_d = ~s1_a_q;
            OP_NAND:  y_d = ~(s1_a_q & s1_b_q);
            OP_NOR:   y_d = ~(s1_a_q | s1_b_q);
            OP_XOR:   y_d = s1_a_q ^ s1_b_q;
            OP_XNOR:  y_d = ~(s1_a_q ^ s1_b_q);
            OP_PASSB: y_d = s1_b_q;
        endcase
    end

    // Saturating count of accepted input beats
    always_comb begin
        cnt_d = cnt_q;
        if (in_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // S1 register: loads only on a valid beat while ready; empties when its beat moves on
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_op_q <= in_op;
                s1_a_q  <= in_a;
                s1_b_q  <= in_b;
            end
        end
    end

    // S2 register: result and flags, held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_op_q    <= '0;
            s2_y_q     <= '0;
            s2_zero_q  <= 1'b1;
            s2_ones_q  <= 1'b0;
            s2_par_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_op_q    <= s1_op_q;
            s2_y_q     <= y_d;
            s2_zero_q  <= ~|y_d;
            s2_ones_q  <= &y_d;
            s2_par_q   <= ^y_d;
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    // Accepted-beat counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PCW-1:0] pc_d;
    logic [PCW-1:0] pc_q;

    // Ones count of the S1 result, loaded alongside it
    always_comb begin
        pc_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc_d = pc_d + PCW'(y_d[i]);
        end
    end

    // Popcount register shares the S2 load/hold timing
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (s2_load) begin
            pc_q <= pc_d;
        end
    end

    assign out_popcnt = pc_q;
`endif

    assign out_valid  = s2_valid_q;
    assign out_y      = s2_y_q;
    assign out_op     = s2_op_q;
    assign out_zero   = s2_zero_q;
    assign out_ones   = s2_ones_q;
    assign out_parity = s2_par_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
// Driver pushes expected beats on accept; monitor pops on each output transfer.
// Covers reset, op sweep, stall/hold, random handshakes, counter saturation, mid-stall reset.
module tb_logic_unit_pipe;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int PCW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [2:0]    out_op;
    logic          out_zero;
    logic          out_ones;
    logic          out_parity;
    logic [CW-1:0] op_count;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PCW-1:0] out_popcnt;
`endif

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
`ifdef LOGIC_UNIT_POPCOUNT_EN
        .out_popcnt(out_popcnt),
`endif
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] y;
        logic         z;
        logic         o;
        logic         p;
        int           pc;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int push_n = 0;
    bit rnd_on = 0;

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_y;
    logic [2:0]   prev_op;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference result for randomized beats
    function automatic exp_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        case (op)
            3'd0: e.y = a & b;
            3'd1: e.y = a | b;
            3'd2: e.y = ~a;
            3'd3: e.y = ~(a & b);
            3'd4: e.y = ~(a | b);
            3'd5: e.y = a ^ b;
            3'd6: e.y = ~(a ^ b);
            default: e.y = b;
        endcase
        e.op = op;
        e.z  = (e.y == 8'h00);
        e.o  = (e.y == 8'hFF);
        e.pc = 0;
        for (int i = 0; i < W; i++) e.pc += int'(e.y[i]);
        e.p   = e.pc[0];
        e.lat = 0;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: compare on every output transfer; also watch held data during stalls
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_y", 32'(out_y), 32'(prev_y));
                chk("hold_op", 32'(out_op), 32'(prev_op));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got y=%0h with empty scoreboard", out_y);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_y", 32'(out_y), 32'(e.y));
                    chk("out_op", 32'(out_op), 32'(e.op));
                    chk("out_zero", 32'(out_zero), 32'(e.z));
                    chk("out_ones", 32'(out_ones), 32'(e.o));
                    chk("out_parity", 32'(out_parity), 32'(e.p));
`ifdef LOGIC_UNIT_POPCOUNT_EN
                    chk("out_popcnt", 32'(out_popcnt), 32'(e.pc));
`endif
                    if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            prev_op    = out_op;
        end
    end

    // Drive one beat (called at posedge+1); returns at posedge+1 after the accepting edge
    task automatic send_e(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        n  = 0;
        ok = 0;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (in_ready) begin
                e.cyc = cyc;
                sb.push_back(e);
                push_n++;
                ok = 1;
            end
            n++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] y, input logic z, input logic o, input logic p,
                        input int pc, input bit lat);
        exp_t e;
        e.op = op; e.y = y; e.z = z; e.o = o; e.p = p; e.pc = pc; e.lat = lat; e.cyc = 0;
        send_e(op, a, b, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_out_ones", 32'(out_ones), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #1;

        // Reset state
        do_reset();

        // Op sweep and flag vectors, back to back, latency 2
        send(3'd0, 8'hF0, 8'hCC, 8'hC0, 0, 0, 0, 2, 1);
        send(3'd1, 8'hF0, 8'hCC, 8'hFC, 0, 0, 0, 6, 1);
        send(3'd2, 8'hF0, 8'hCC, 8'h0F, 0, 0, 0, 4, 1);
        send(3'd3, 8'hF0, 8'hCC, 8'h3F, 0, 0, 0, 6, 1);
        send(3'd4, 8'hF0, 8'hCC, 8'h03, 0, 0, 0, 2, 1);
        send(3'd5, 8'hF0, 8'hCC, 8'h3C, 0, 0, 0, 4, 1);
        send(3'd6, 8'hF0, 8'hCC, 8'hC3, 0, 0, 0, 4, 1);
        send(3'd7, 8'hF0, 8'hCC, 8'hCC, 0, 0, 0, 4, 1);
        send(3'd4, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 0, 1);
        send(3'd1, 8'hF0, 8'h0F, 8'hFF, 0, 1, 0, 8, 1);
        send(3'd5, 8'h01, 8'h00, 8'h01, 0, 0, 1, 1, 1);
        send(3'd6, 8'hAA, 8'h55, 8'h00, 1, 0, 0, 0, 1);
        send(3'd7, 8'h12, 8'h07, 8'h07, 0, 0, 1, 3, 1);
        send(3'd2, 8'h00, 8'h5A, 8'hFF, 0, 1, 0, 8, 1);
        send(3'd0, 8'h7F, 8'h3F, 8'h3F, 0, 0, 0, 6, 1);
        send(3'd1, 8'hB5, 8'h00, 8'hB5, 0, 0, 1, 5, 1);
        in_valid = 1'b0;
        drain();

        // Backpressure: two beats fill the pipe, the third waits
        out_ready = 1'b0;
        base = push_n;
        fork
            begin
                send(3'd0, 8'hF0, 8'hCC, 8'hC0, 0, 0, 0, 2, 0);
                send(3'd5, 8'hF0, 8'hCC, 8'h3C, 0, 0, 0, 4, 0);
                send(3'd2, 8'hF0, 8'hCC, 8'h0F, 0, 0, 0, 4, 0);
                in_valid = 1'b0;
            end
        join_none
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_accepted", 32'(push_n - base), 32'd2);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_y", 32'(out_y), 32'hC0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();

        // Random valid/ready toggling against the reference function
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                if (rnd_on) out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            int gap;
            op  = 3'($urandom_range(0, 7));
            a   = 8'($urandom);
            b   = 8'($urandom);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                in_valid = 1'b0;
                in_a     = 8'($urandom);
                repeat (gap) @(posedge clk);
                #1;
            end
            send_e(op, a, b, mk(op, a, b));
        end
        in_valid = 1'b0;
        rnd_on   = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drain();

        // Counter saturation after a fresh reset
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_e(3'd7, 8'h00, 8'(i), mk(3'd7, 8'h00, 8'(i)));
        end
        in_valid = 1'b0;
        drain();
        chk("op_count_sat", 32'(op_count), 32'd15);

        // Reset while both stages are full and stalled
        out_ready = 1'b0;
        send(3'd0, 8'hFF, 8'h81, 8'h81, 0, 0, 0, 2, 0);
        send(3'd1, 8'h01, 8'h02, 8'h03, 0, 0, 0, 2, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b1;
        send(3'd5, 8'h0F, 8'hFF, 8'hF0, 0, 0, 0, 4, 1);
        in_valid = 1'b0;
        drain();
        chk("op_count_after", 32'(op_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
